// File: rtl/aes_encoder.sv
// Fully pipelined AES-128 encryption core: one block and key accepted per clock,
// each register stage holds the state after one round plus that round's key.
module aes_encoder #(
  parameter int NUM_ROUNDS = 10
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [127:0] plain_in,
  input  logic [127:0] key_in,
  output logic [127:0] cipher_out,
  output logic         valid_out
);

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] sh;
    logic [7:0] bits;
    acc  = 8'h00;
    sh   = a;
    bits = b;
    for (int i = 0; i < 8; i++) begin
      if (bits[0]) acc = acc ^ sh;
      sh   = xtime(sh);
      bits = {1'b0, bits[7:1]};
    end
    return acc;
  endfunction

  // Inverse is x^254 (which also maps 0 to 0), then the fixed affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = x;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gfMul(sq, sq);
      inv = gfMul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] subWord(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] rconOf(input int r);
    logic [7:0] rc;
    case (r)
      1:       rc = 8'h01;
      2:       rc = 8'h02;
      3:       rc = 8'h04;
      4:       rc = 8'h08;
      5:       rc = 8'h10;
      6:       rc = 8'h20;
      7:       rc = 8'h40;
      8:       rc = 8'h80;
      9:       rc = 8'h1b;
      10:      rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

  function automatic logic [127:0] keyExpand(input logic [127:0] k, input logic [7:0] rcon);
    logic [31:0] w4;
    logic [31:0] w5;
    logic [31:0] w6;
    logic [31:0] w7;
    w4 = k[127:96] ^ subWord({k[23:0], k[31:24]}) ^ {rcon, 24'h000000};
    w5 = k[95:64] ^ w4;
    w6 = k[63:32] ^ w5;
    w7 = k[31:0] ^ w6;
    return {w4, w5, w6, w7};
  endfunction

  // Byte b sits at bits [127-8b -: 8]; row r of column c is byte r+4c.
  function automatic logic [127:0] shiftRows(input logic [127:0] s);
    return {s[127:120], s[87:80],   s[47:40],   s[7:0],
            s[95:88],   s[55:48],   s[15:8],    s[103:96],
            s[63:56],   s[23:16],   s[111:104], s[71:64],
            s[31:24],   s[119:112], s[79:72],   s[39:32]};
  endfunction

  function automatic logic [31:0] mixColumn(input logic [31:0] col);
    logic [7:0] a0;
    logic [7:0] a1;
    logic [7:0] a2;
    logic [7:0] a3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic logic [127:0] cipherRound(input logic [127:0] s, input logic [127:0] rk,
                                               input logic lastRound);
    logic [127:0] rest;
    logic [127:0] sub;
    logic [127:0] shifted;
    logic [127:0] mixed;
    rest = s;
    sub  = '0;
    for (int i = 0; i < 16; i++) begin
      sub  = {sub[119:0], sbox(rest[127:120])};
      rest = {rest[119:0], 8'h00};
    end
    shifted = shiftRows(sub);
    mixed   = {mixColumn(shifted[127:96]), mixColumn(shifted[95:64]),
               mixColumn(shifted[63:32]),  mixColumn(shifted[31:0])};
    return (lastRound ? shifted : mixed) ^ rk;
  endfunction

  logic [127:0]        stateD [1:NUM_ROUNDS];
  logic [127:0]        stateQ [1:NUM_ROUNDS];
  logic [127:0]        keyD   [1:NUM_ROUNDS];
  logic [127:0]        keyQ   [1:NUM_ROUNDS-1];
  logic [NUM_ROUNDS:1] validQ;

  // Stage 1 absorbs the initial AddRoundKey and round 1; the last stage needs no stored key.
  for (genvar r = 1; r <= NUM_ROUNDS; r++) begin : g_stage
    if (r == 1) begin : g_first
      assign keyD[r]   = keyExpand(key_in, rconOf(r));
      assign stateD[r] = cipherRound(plain_in ^ key_in, keyD[r], 1'b0);
    end else begin : g_next
      assign keyD[r]   = keyExpand(keyQ[r-1], rconOf(r));
      assign stateD[r] = cipherRound(stateQ[r-1], keyD[r], r == NUM_ROUNDS);
    end

    always_ff @(posedge clock) begin
      if (reset) stateQ[r] <= '0;
      else       stateQ[r] <= stateD[r];
    end

    if (r < NUM_ROUNDS) begin : g_key
      always_ff @(posedge clock) begin
        if (reset) keyQ[r] <= '0;
        else       keyQ[r] <= keyD[r];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) validQ <= '0;
    else       validQ <= {validQ[NUM_ROUNDS-1:1], 1'b1};
  end

  assign cipher_out = stateQ[NUM_ROUNDS];
  assign valid_out  = validQ[NUM_ROUNDS];

endmodule

// File: tb/tb_aes_encoder.sv
// Testbench for aes_encoder: known-answer table plus random blocks checked against
// a byte-array AES-128 reference model, with reset and back-to-back key changes.
module tb_aes_encoder;

  localparam int NR   = 10;
  localparam int MAXE = 2048;

  logic         clock = 1'b0;
  logic         reset;
  logic [127:0] plain_in;
  logic [127:0] key_in;
  logic [127:0] cipher_out;
  logic         valid_out;

  always #5 clock = ~clock;

  aes_encoder #(.NUM_ROUNDS(NR)) dut (
    .clock      (clock),
    .reset      (reset),
    .plain_in   (plain_in),
    .key_in     (key_in),
    .cipher_out (cipher_out),
    .valid_out  (valid_out)
  );

  typedef struct {
    logic [127:0] plain;
    logic [127:0] key;
    logic [127:0] cipher;
  } vec_t;

  vec_t         vecs [3];
  logic [7:0]   sboxTab [256];
  logic [127:0] hPlain [MAXE];
  logic [127:0] hKey   [MAXE];
  logic [127:0] hKaVal [MAXE];
  bit           hRst   [MAXE];
  bit           hKa    [MAXE];
  int           edgeCnt     = 0;
  int           nCompared   = 0;
  int           nMismatched = 0;

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  function automatic logic [7:0] mul2(input logic [7:0] v);
    return v[7] ? ((v << 1) ^ 8'h1b) : (v << 1);
  endfunction

  // Classic generator walk: p steps through powers of 3, q through powers of 3^-1.
  task automatic buildSbox();
    logic [7:0] p;
    logic [7:0] q;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ (q << 1);
      q = q ^ (q << 2);
      q = q ^ (q << 4);
      if (q[7]) q = q ^ 8'h09;
      sboxTab[p] = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4) ^ 8'h63;
    end while (p != 8'h01);
    sboxTab[0] = 8'h63;
  endtask

  function automatic logic [127:0] refAes(input logic [127:0] pt, input logic [127:0] key);
    logic [31:0]  w [44];
    logic [7:0]   st [16];
    logic [7:0]   tmp [16];
    logic [31:0]  t;
    logic [7:0]   rc;
    logic [127:0] res;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sboxTab[t[23:16]], sboxTab[t[15:8]], sboxTab[t[7:0]], sboxTab[t[31:24]]} ^ {rc, 24'h0};
        rc = mul2(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int i = 0; i < 16; i++) st[i] = pt[127 - 8*i -: 8] ^ w[i/4][31 - 8*(i%4) -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int i = 0; i < 16; i++) st[i] = sboxTab[st[i]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) tmp[r + 4*c] = st[r + 4*((c + r) % 4)];
      for (int c = 0; c < 4; c++) begin
        if (rnd == 10) begin
          for (int r = 0; r < 4; r++) st[r + 4*c] = tmp[r + 4*c];
        end else begin
          for (int r = 0; r < 4; r++)
            st[r + 4*c] = mul2(tmp[4*c + r]) ^ mul2(tmp[4*c + (r+1)%4]) ^ tmp[4*c + (r+1)%4]
                        ^ tmp[4*c + (r+2)%4] ^ tmp[4*c + (r+3)%4];
        end
      end
      for (int i = 0; i < 16; i++) st[i] = st[i] ^ w[4*rnd + i/4][31 - 8*(i%4) -: 8];
    end
    for (int i = 0; i < 16; i++) res[127 - 8*i -: 8] = st[i];
    return res;
  endfunction

  function automatic logic [127:0] randBlock();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic compare(input string name, input logic [127:0] actual, input logic [127:0] required);
    nCompared++;
    if (actual !== required) begin
      nMismatched++;
      $display("[TB] FAIL %s at edge %0d: got %h, want %h", name, edgeCnt, actual, required);
    end
  endtask

  // A block is visible once the ten most recent edges were all free of reset.
  task automatic checkOutput();
    bit expValid;
    int src;
    expValid = 1'b1;
    for (int i = 0; i < NR; i++)
      if (edgeCnt - i < 1 || hRst[edgeCnt - i]) expValid = 1'b0;
    compare("valid_out", {127'b0, valid_out}, {127'b0, expValid});
    if (hRst[edgeCnt]) compare("reset_cipher", cipher_out, 128'h0);
    if (expValid) begin
      src = edgeCnt - (NR - 1);
      compare("model_cipher", cipher_out, refAes(hPlain[src], hKey[src]));
      if (hKa[src]) compare("known_answer", cipher_out, hKaVal[src]);
    end
  endtask

  task automatic applyStimulus(input logic [127:0] p, input logic [127:0] k, input bit r,
                               input bit ka, input logic [127:0] kaVal);
    @(negedge clock);
    plain_in = p;
    key_in   = k;
    reset    = r;
    @(posedge clock);
    if (edgeCnt >= MAXE - 1) begin
      $display("[TB] FAIL edge_budget: got %0d edges, want fewer than %0d", edgeCnt, MAXE);
      $fatal(1, "[TB] edge budget exhausted");
    end
    edgeCnt++;
    hPlain[edgeCnt] = p;
    hKey[edgeCnt]   = k;
    hRst[edgeCnt]   = r;
    hKa[edgeCnt]    = ka;
    hKaVal[edgeCnt] = kaVal;
    #1;
    checkOutput();
  endtask

  initial begin
    buildSbox();
    vecs[0] = '{128'h0, 128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e};
    vecs[1] = '{128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f,
                128'h69c4e0d86a7b0430d8cdb78070b4c55a};
    vecs[2] = '{128'h3243f6a8885a308d313198a2e0370734, 128'h2b7e151628aed2a6abf7158809cf4f3c,
                128'h3925841d02dc09fbdc118597196a0b32};
    reset    = 1'b1;
    plain_in = '0;
    key_in   = '0;

    $display("[TB] reset held three cycles with random inputs");
    for (int i = 0; i < 3; i++) applyStimulus(randBlock(), randBlock(), 1'b1, 1'b0, '0);

    $display("[TB] known-answer vectors back to back from the first edge after reset");
    for (int i = 0; i < 3; i++) applyStimulus(vecs[i].plain, vecs[i].key, 1'b0, 1'b1, vecs[i].cipher);

    $display("[TB] random stream with a fresh key every cycle");
    for (int i = 0; i < 200; i++) applyStimulus(randBlock(), randBlock(), 1'b0, 1'b0, '0);

    $display("[TB] one-cycle reset with the pipeline full");
    applyStimulus(randBlock(), randBlock(), 1'b1, 1'b0, '0);
    for (int i = 0; i < 14; i++) applyStimulus(randBlock(), randBlock(), 1'b0, 1'b0, '0);

    $display("[TB] known-answer vectors interleaved with random blocks");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(vecs[i].plain, vecs[i].key, 1'b0, 1'b1, vecs[i].cipher);
      applyStimulus(randBlock(), vecs[i].key, 1'b0, 1'b0, '0);
    end

    $display("[TB] random blocks under a shared key, then drain");
    begin
      logic [127:0] sharedKey;
      sharedKey = randBlock();
      for (int i = 0; i < 20; i++) applyStimulus(randBlock(), sharedKey, 1'b0, 1'b0, '0);
    end
    for (int i = 0; i < NR + 2; i++) applyStimulus(randBlock(), randBlock(), 1'b0, 1'b0, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
